// File: rtl/regfile_pkg.sv
// Shared types and sizes for the two-requester register file arbiter.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 2;
  localparam int unsigned REG_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Request fields latched from the winning requester
  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input winner select: a lone requester wins, ties go to the side ptr favours (1 = B).
module rr_arb2 (
  input  logic req_a,
  input  logic req_b,
  input  logic ptr,
  output logic win_b
);

  assign win_b = req_b & (~req_a | ptr);

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto one register file port with a fixed 3-cycle handshake.
// Define REGFILE_ARB_RR_EN for round-robin tie breaking; otherwise A always wins ties.
module regfile_arbiter
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic [REG_ADDR_W-1:0] addr_a,
  input  logic [REG_ADDR_W-1:0] addr_b,
  input  logic [REG_DATA_W-1:0] wdata_a,
  input  logic [REG_DATA_W-1:0] wdata_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  done_a,
  output logic                  done_b,
  output logic [REG_DATA_W-1:0] rdata,
  output logic [REG_ADDR_W-1:0] rf_read_add,
  output logic [REG_ADDR_W-1:0] rf_write_add,
  output logic                  rf_read_en,
  output logic                  rf_write_en,
  output logic [REG_DATA_W-1:0] rf_data_in,
  input  logic [REG_DATA_W-1:0] rf_data_out
);

  state_t                r_state, w_state_nxt;
  logic                  r_win_b, w_win_b_nxt;
  logic                  r_gnt_a, w_gnt_a;
  logic                  r_gnt_b, w_gnt_b;
  logic                  r_done_a, w_done_a;
  logic                  r_done_b, w_done_b;
  logic                  r_rd_en, w_rd_en;
  logic                  r_wr_en, w_wr_en;
  logic [REG_ADDR_W-1:0] r_addr, w_addr;
  logic [REG_DATA_W-1:0] r_din, w_din;
  logic [REG_DATA_W-1:0] r_rdata, w_rdata;
  logic                  w_ptr;
  logic                  w_win_b;
  req_t                  w_sel;

`ifdef REGFILE_ARB_RR_EN
  logic r_ptr, w_ptr_nxt;
  assign w_ptr = r_ptr;
`else
  assign w_ptr = 1'b0;
`endif

  rr_arb2 u_rr_arb2 (
    .req_a (req_a),
    .req_b (req_b),
    .ptr   (w_ptr),
    .win_b (w_win_b)
  );

  assign w_sel = w_win_b ? {we_b, addr_b, wdata_b} : {we_a, addr_a, wdata_a};

  // Next state and next registered outputs; everything holds unless a state says otherwise
  always_comb begin
    w_state_nxt = r_state;
    w_win_b_nxt = r_win_b;
    w_gnt_a     = 1'b0;
    w_gnt_b     = 1'b0;
    w_done_a    = 1'b0;
    w_done_b    = 1'b0;
    w_rd_en     = 1'b0;
    w_wr_en     = 1'b0;
    w_addr      = r_addr;
    w_din       = r_din;
    w_rdata     = r_rdata;
`ifdef REGFILE_ARB_RR_EN
    w_ptr_nxt   = r_ptr;
`endif
    case (r_state)
      IDLE: begin
        if (req_a || req_b) begin
          w_state_nxt = ACCESS;
          w_win_b_nxt = w_win_b;
          w_gnt_a     = ~w_win_b;
          w_gnt_b     = w_win_b;
          w_wr_en     = w_sel.we;
          w_rd_en     = ~w_sel.we;
          w_addr      = w_sel.addr;
          w_din       = w_sel.wdata;
        end
      end
      ACCESS: begin
        w_state_nxt = RESP;
        w_done_a    = ~r_win_b;
        w_done_b    = r_win_b;
        if (r_rd_en) w_rdata = rf_data_out;
      end
      RESP: begin
        w_state_nxt = IDLE;
`ifdef REGFILE_ARB_RR_EN
        w_ptr_nxt   = ~r_win_b;
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_win_b  <= 1'b0;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
      r_rd_en  <= 1'b0;
      r_wr_en  <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
      r_rdata  <= '0;
`ifdef REGFILE_ARB_RR_EN
      r_ptr    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_win_b  <= w_win_b_nxt;
      r_gnt_a  <= w_gnt_a;
      r_gnt_b  <= w_gnt_b;
      r_done_a <= w_done_a;
      r_done_b <= w_done_b;
      r_rd_en  <= w_rd_en;
      r_wr_en  <= w_wr_en;
      r_addr   <= w_addr;
      r_din    <= w_din;
      r_rdata  <= w_rdata;
`ifdef REGFILE_ARB_RR_EN
      r_ptr    <= w_ptr_nxt;
`endif
    end
  end

  assign gnt_a        = r_gnt_a;
  assign gnt_b        = r_gnt_b;
  assign done_a       = r_done_a;
  assign done_b       = r_done_b;
  assign rdata        = r_rdata;
  assign rf_read_add  = r_addr;
  assign rf_write_add = r_addr;
  assign rf_read_en   = r_rd_en;
  assign rf_write_en  = r_wr_en;
  assign rf_data_in   = r_din;

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001: Module SHALL have one clock and a synchronous, active-low reset.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004: req_a / req_b  input  1  access request from requester A / B; held high until gnt seen.
REQ-005: we_a / we_b  input  1  1 = write, 0 = read; qualified by req.
REQ-006: addr_a / addr_b  input  2  register address 0..3.
REQ-007: wdata_a / wdata_b  input  4  write data.
REQ-008: gnt_a / gnt_b  output  1  one-cycle pulse: request accepted, fields may change.
REQ-009: done_a / done_b  output  1  one-cycle pulse: access complete; rdata valid if read.
REQ-010: rdata  output  4  read result, shared by both requesters, held until next read completes.
REQ-011: rf_read_add / rf_write_add  output  2  register file read / write address.
REQ-012: rf_read_en / rf_write_en  output  1  register file read / write enable.
REQ-013: rf_data_in  output  4  register file write data.
REQ-014: rf_data_out  input  4  register file read data, combinational from rf_read_add/rf_read_en.

Function
REQ-015: FSM SHALL have states IDLE, ACCESS, RESP; all outputs SHALL be driven from registers.
REQ-016: IDLE: if req_a or req_b is high, SHALL pick a winner, latch its we/addr/wdata, and go to ACCESS; otherwise SHALL stay in IDLE.
REQ-017: ACCESS (exactly 1 cycle): gnt of the winner SHALL be high; rf_write_en = latched we, rf_read_en = !latched we; both rf addresses = latched addr; rf_data_in = latched wdata.
REQ-018: ACCESS: on a read, rf_data_out SHALL be captured into rdata at the closing edge; on a write, rdata SHALL be unchanged.
REQ-019: RESP (exactly 1 cycle): done of the winner SHALL be high; all rf enables and gnts SHALL be 0; next state SHALL be IDLE.
REQ-020: Latency SHALL be fixed: req sampled in IDLE at cycle N; gnt/ACCESS at N+1; done/RESP at N+2; next acceptance at earliest in cycle N+3 (IDLE).
REQ-021: Simultaneous req_a and req_b: winner SHALL follow the priority pointer; the loser SHALL stay pending with no gnt.
REQ-022: The priority pointer SHALL move to favour the non-winner on leaving RESP.
REQ-023: A single active requester SHALL always win, regardless of the pointer.
REQ-024: A req still high in IDLE after its own done SHALL be treated as a new request.
REQ-025: A req dropped before its gnt SHALL have undefined effect; benches SHALL NOT do this.
REQ-026: At most one gnt and one done SHALL be high in any cycle; rf_read_en and rf_write_en SHALL never both be high.

Reset
REQ-027: With rst_n low at a rising edge, at that edge: state = IDLE; pointer favours A; all gnt, done, rf enables = 0; rf addresses, rf_data_in and rdata = 0.
REQ-028: Reset in ACCESS or RESP SHALL abort the access with no done pulse; a write already enabled for that cycle is not undone.

Configuration
REQ-029: Macro REGFILE_ARB_RR_EN defined: round-robin pointer per REQ-022.
REQ-030: Macro REGFILE_ARB_RR_EN undefined: fixed priority with A always winning ties; the pointer register SHALL be absent.

Structure
REQ-031: A shared package regfile_pkg SHALL hold the FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), REG_ADDR_W=2 and REG_DATA_W=4.
REQ-032: The two-input winner selection SHALL be a sub-module rr_arb2 (inputs req_a, req_b, ptr; output win_b).

Verification
REQ-033: After reset, req_a=1, we_a=1, addr_a=2, wdata_a=4'hA -> gnt_a and rf_write_en with rf_write_add=2, rf_data_in=4'hA at N+1; done_a at N+2.
REQ-034: Following REQ-033, req_b=1, we_b=0, addr_b=2 -> rf_read_en at N+1; done_b at N+2 with rdata=4'hA.
REQ-035: req_a and req_b held high together for 12 cycles -> with REGFILE_ARB_RR_EN: grants A,B,A,B (one per 3 cycles); without it: grants A,A,A,A.
REQ-036: rst_n low for one edge during ACCESS of a read -> next cycle all outputs 0, no done; fresh req_b served as first access with A still favoured.
REQ-037: Idle for 5 cycles with no req -> no gnt, done or rf enable asserted; rdata holds its last value.
